// File: rtl/mtm_alu_pkg.sv
// ============================================================================
// mtm_alu_pkg : shared types and constants for the ALU serial link
// Rev 1.0
// ============================================================================
`default_nettype none

package mtm_alu_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_START   = 3'd1,
      S_TYPE    = 3'd2,
      S_PAYLOAD = 3'd3,
      S_STOP    = 3'd4,
      S_GAP     = 3'd5,
      S_DONE    = 3'd6
   } state_t;

   localparam logic       TYPE_DATA  = 1'b0;
   localparam logic       TYPE_CTL   = 1'b1;
   localparam logic [2:0] CRC3_POLY  = 3'b011;   // x^3 + x + 1, x^3 term implied
   localparam int         FRAME_LEN  = 11;
   localparam logic       ERR_MARKER = 1'b1;
   localparam logic       RES_MARKER = 1'b0;

endpackage

`default_nettype wire

// File: rtl/mtm_alu_crc3.sv
// ============================================================================
// mtm_alu_crc3 : combinational CRC3 (x^3+x+1, init 0) over 37 bits, MSB first
// Rev 1.0
// ============================================================================
`default_nettype none

module mtm_alu_crc3
   import mtm_alu_pkg::*;
(
   input  logic [36:0] data,
   output logic [2:0]  crc
);

   logic [2:0] w_crc;

   always_comb begin
      w_crc = 3'b000;
      for (int i = 36; i >= 0; i--) begin
         if (w_crc[2] ^ data[i])
            w_crc = {w_crc[1:0], 1'b0} ^ CRC3_POLY;
         else
            w_crc = {w_crc[1:0], 1'b0};
      end
   end

   assign crc = w_crc;

endmodule

`default_nettype wire

// File: rtl/mtm_alu_serializer.sv
// ============================================================================
// mtm_alu_serializer : frames an ALU result or error report onto sout
// Rev 1.0
// ============================================================================
`default_nettype none

module mtm_alu_serializer
   import mtm_alu_pkg::*;
#(
   parameter int DATA_BYTES = 4,
   parameter int IDLE_GAP   = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid,
   input  logic        is_err,
   input  logic [31:0] C,
   input  logic [3:0]  FLAGS,
   input  logic [5:0]  ERR,
   output logic        busy,
   output logic        done,
   output logic        sout
);

   localparam int FRAME_W = $clog2(DATA_BYTES + 1);
   localparam int GAP_W   = (IDLE_GAP > 1) ? $clog2(IDLE_GAP + 1) : 1;
   localparam logic [FRAME_W-1:0] c_last_frame = FRAME_W'(DATA_BYTES);

   state_t             r_state, w_state_n;
   logic [2:0]         r_bit, w_bit_n;
   logic [FRAME_W-1:0] r_frame, w_frame_n;
   logic [GAP_W-1:0]   r_gap, w_gap_n;
   logic [31:0]        r_c;
   logic [7:0]         r_ctl;
   logic               r_sout, w_sout_n;
   logic               w_accept;
   logic [2:0]         w_crc;
   logic [7:0]         w_byte;

   mtm_alu_crc3 u_crc3 (
      .data ({C, 1'b0, FLAGS}),
      .crc  (w_crc)
   );

   // The DONE cycle also accepts, so back-to-back packets need no idle cycle.
   assign w_accept = valid && ((r_state == S_IDLE) || (r_state == S_DONE));

   always_comb begin
      w_state_n = r_state;
      w_bit_n   = r_bit;
      w_frame_n = r_frame;
      w_gap_n   = r_gap;
      w_sout_n  = 1'b1;
      case (r_state)
         S_IDLE, S_DONE: begin
            w_state_n = S_IDLE;
            if (w_accept) begin
               w_state_n = S_START;
               w_frame_n = is_err ? c_last_frame : '0;
            end
         end
         S_START: w_state_n = S_TYPE;
         S_TYPE: begin
            w_state_n = S_PAYLOAD;
            w_bit_n   = 3'd7;
         end
         S_PAYLOAD: begin
            if (r_bit == 3'd0)
               w_state_n = S_STOP;
            else
               w_bit_n = r_bit - 3'd1;
         end
         S_STOP: begin
            if (r_frame == c_last_frame) begin
               w_state_n = S_DONE;
            end else begin
               w_frame_n = r_frame + 1'b1;
               if (IDLE_GAP > 0) begin
                  w_state_n = S_GAP;
                  w_gap_n   = GAP_W'(IDLE_GAP - 1);
               end else begin
                  w_state_n = S_START;
               end
            end
         end
         S_GAP: begin
            if (r_gap == '0)
               w_state_n = S_START;
            else
               w_gap_n = r_gap - 1'b1;
         end
         default: w_state_n = S_IDLE;
      endcase

      // sout is registered, so the bit is chosen from the upcoming state.
      w_byte = (w_frame_n == c_last_frame) ? r_ctl : r_c[31:24];
      case (w_state_n)
         S_START:   w_sout_n = 1'b0;
         S_TYPE:    w_sout_n = (w_frame_n == c_last_frame) ? TYPE_CTL : TYPE_DATA;
         S_PAYLOAD: w_sout_n = w_byte[w_bit_n];
         default:   w_sout_n = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_bit   <= '0;
         r_frame <= '0;
         r_gap   <= '0;
         r_sout  <= 1'b1;
      end else begin
         r_state <= w_state_n;
         r_bit   <= w_bit_n;
         r_frame <= w_frame_n;
         r_gap   <= w_gap_n;
         r_sout  <= w_sout_n;
      end
   end

   // Data bytes leave MSB first; shifting after each payload keeps the next byte on top.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_c   <= '0;
         r_ctl <= '0;
      end else if (w_accept) begin
         r_c   <= C;
         r_ctl <= is_err ? {ERR_MARKER, ERR, ~^ERR} : {RES_MARKER, FLAGS, w_crc};
      end else if ((r_state == S_PAYLOAD) && (r_bit == 3'd0)) begin
         r_c <= {r_c[23:0], 8'h00};
      end
   end

   assign busy = (r_state != S_IDLE) && (r_state != S_DONE);
   assign done = (r_state == S_DONE);
   assign sout = r_sout;

endmodule

`default_nettype wire

// File: doc/mtm_alu_serializer.md
Name: mtm_alu_serializer

Overview:
Transmit side of the ALU serial link. It takes a finished ALU result (C, flags) or an error report and frames it onto the single-bit output line sout. It uses the same 11-bit frame format the input side parses. It sits between the ALU core and the chip output pin.

Parameters:
DATA_BYTES, 4, number of data frames carrying C (MSB byte first)
IDLE_GAP, 0, idle cycles (sout=1) inserted between consecutive frames of one packet

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-high reset
valid  input  1  request to send; sampled only when busy=0
is_err  input  1  1 = send an error packet, 0 = send a result packet
C  input  32  ALU result
FLAGS  input  4  ALU flags {carry, overflow, zero, negative}
ERR  input  6  error flags; used when is_err=1
busy  output  1  packet in progress
done  output  1  one-cycle pulse after the last stop bit
sout  output  1  serial line; idles high

Behaviour:
- Reset: one clock, asynchronous, active-high. rst=1 immediately forces sout=1, busy=0, done=0, state=IDLE and clears all counters.
- Frame format, 11 cycles per frame, one bit per clk: start 0, type bit (0=data, 1=ctl), 8 payload bits MSB first, stop 1.
- Result packet: DATA_BYTES data frames carrying C[31:24], C[23:16], C[15:8], C[7:0], then one ctl frame with payload {1'b0, FLAGS[3:0], CRC3[2:0]}.
- CRC3: polynomial x^3+x+1, init 000, computed over the 37-bit vector {C, 1'b0, FLAGS}, MSB first.
- Error packet: a single ctl frame with payload {1'b1, ERR[5:0], P}, where P = XOR of payload bits 7..1.
- Accept: valid=1 with busy=0 at edge N latches C/FLAGS/ERR/is_err and precomputes CRC/parity. busy=1 from cycle N+1. The first start bit is driven on sout in cycle N+1.
- Latency (IDLE_GAP=0):
  - result packet: bits occupy cycles N+1..N+55, done=1 and busy=0 at N+56.
  - error packet: bits occupy N+1..N+11, done at N+12.
- IDLE_GAP=g: g cycles of sout=1 between frames, none after the last frame. Result packet length is 55+4g.
- FSM states: IDLE -> START -> TYPE -> PAYLOAD (3-bit bit counter 7..0) -> STOP -> (GAP when IDLE_GAP>0) -> START of next frame, or DONE after the last frame. DONE -> IDLE after one cycle.
- Frame counter counts 0..DATA_BYTES. Error packets jump straight to the ctl frame.
- sout is registered; no combinational path from inputs to sout.
- valid while busy=1 is ignored; inputs are not re-sampled.
- valid=1 in the DONE cycle is accepted, so the next start bit follows without an idle cycle.
- Inputs may change freely after acceptance without affecting the packet in flight.
- Reset mid-packet: the packet is abandoned and sout=1 immediately. The next packet restarts at frame 0.

Decomposition:
- Package mtm_alu_pkg holds:
  - FSM state enum
  - frame type constants (TYPE_DATA=0, TYPE_CTL=1)
  - CRC3 polynomial constant
  - frame length (11)
  - error-payload MSB marker
- One combinational sub-module, mtm_alu_crc3: 37-bit input, 3-bit CRC output. It is shared with the checker model.

Test Plan:
1. Hold rst=1, then release -> sout=1, busy=0, done=0; nothing transmits without valid.
2. C=32'h0, FLAGS=0, is_err=0, valid pulse -> 4 frames of 0,0,00000000,1, then ctl frame 0,1,00000000,1. done at cycle 56 after accept.
3. is_err=1, ERR=6'b100100 -> single frame 0,1,11001001,1 (payload 0xC9). done 12 cycles after accept; C and FLAGS are ignored.
4. C=32'hDEADBEEF, FLAGS=4'b1000 -> payload bytes DE, AD, BE, EF, then {0,1000,CRC3} with CRC3 equal to the golden model over {C,0,FLAGS}.
5. valid held through a whole packet with new C mid-packet -> the first packet is unchanged. A second packet starts immediately after done using the C sampled in the DONE cycle.
6. rst pulse during the payload of frame 2 -> sout=1 in the same cycle as rst. A subsequent valid produces a complete packet from frame 0. Repeat test 2 with IDLE_GAP=2 -> 2 high cycles between frames, done at cycle 64.
